// File: rtl/ram_program_loader.sv
// Loads a full program image from a byte stream into RAM through its manual
// programming port, then optionally reads every word back and compares it to a shadow copy.
module ram_program_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              manual_mode,
  output logic              manual_read,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] program_switches,
  input  logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] error_addr
);

  typedef enum logic [3:0] {
    IDLE, FETCH, SETUP, STROBE, ADV, VADDR, VWAIT, VCHECK, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [1:0]        WAIT_LAST = 2'(READ_LAT - 1);

  state_t            state;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] shadow [2**ADDR_W];

  // Outputs decode the state register directly, so they change only on clock edges.
  assign byte_ready  = (state == FETCH);
  assign manual_read = (state == STROBE);
  assign manual_mode = (state != IDLE) && (state != DONE);
  assign busy        = manual_mode;
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      address          <= '0;
      program_switches <= '0;
      error            <= 1'b0;
      error_addr       <= '0;
      wait_cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state      <= FETCH;
          address    <= '0;
          error      <= 1'b0;
          error_addr <= '0;
        end
        FETCH: if (byte_valid) begin
          program_switches <= byte_in;
          state            <= SETUP;
        end
        SETUP:  state <= STROBE;
        STROBE: state <= ADV;
        ADV: begin
          if (address == ADDR_MAX) begin
            address <= '0;
            state   <= (VERIFY_EN != 0) ? VADDR : DONE;
          end else begin
            address <= address + 1'b1;
            state   <= FETCH;
          end
        end
        VADDR: begin
          wait_cnt <= '0;
          state    <= VWAIT;
        end
        VWAIT: begin
          if (wait_cnt == WAIT_LAST) state <= VCHECK;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        VCHECK: begin
          // Only the first mismatch is recorded.
          if (ram_data != shadow[address] && !error) begin
            error      <= 1'b1;
            error_addr <= address;
          end
          if (address == ADDR_MAX) state <= DONE;
          else begin
            address <= address + 1'b1;
            state   <= VADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == FETCH && byte_valid) shadow[address] <= byte_in;
  end

endmodule
